// File: rtl/vector_reg_file.sv
// vector_reg_file: parametrised SIMD register file with per-lane write masks and a
// sequential bulk-clear engine. Define VRF_WRITE_BYPASS_EN for same-cycle write-to-read bypass.
module vector_reg_file #(
  parameter int LANES = 16,
  parameter int LANE_W = 8,
  parameter int NREGS = 16,
  parameter int NRD = 3,
  parameter logic [LANE_W-1:0] R0_LANE_INIT = 8'hFA,
  parameter int SP_IDX = 13,
  parameter logic [127:0] SP_INIT = 128'h2000,
  localparam int DATA_W = LANES * LANE_W,
  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [AW-1:0]           wa,
  input  logic [DATA_W-1:0]       wd,
  input  logic [LANES-1:0]        wmask,
  output logic                    wr_rdy,
  input  logic [NRD*AW-1:0]       ra,
  output logic [NRD*DATA_W-1:0]   rd,
  input  logic                    clr_req,
  output logic                    clr_busy,
  output logic                    clr_done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [AW-1:0]     LAST_IDX = AW'(NREGS - 1);
  localparam logic [DATA_W-1:0] SP_IMG   = DATA_W'(SP_INIT);

  // Value register idx takes on reset and at the end of a bulk clear.
  function automatic logic [DATA_W-1:0] image_of(input int idx);
    logic [DATA_W-1:0] v;
    v = '0;
    if (idx == 0)           v = {LANES{R0_LANE_INIT}};
    else if (idx == SP_IDX) v = SP_IMG;
    return v;
  endfunction

  logic [DATA_W-1:0] rf_q [NREGS];
  logic [DATA_W-1:0] rf_d [NREGS];
  logic [1:0]        state_q, state_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic              wa_hit;
  logic              wr_en;
  logic [DATA_W-1:0] wr_merged;

  assign wr_rdy   = (state_q == ST_IDLE);
  assign clr_busy = (state_q == ST_CLEAR);
  assign clr_done = (state_q == ST_DONE);

  // Masked lanes keep the addressed register's current contents; an address with no
  // matching register leaves wa_hit low, which drops the write.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    wa_hit    = 1'b0;
    wr_merged = '0;
    for (int r = 0; r < NREGS; r++) begin
      if (wa == AW'(r)) begin
        wa_hit    = 1'b1;
        wr_merged = rf_q[r];
      end
    end
    for (int i = 0; i < LANES; i++) begin
      if (wmask[i]) wr_merged[i*LANE_W +: LANE_W] = wd[i*LANE_W +: LANE_W];
    end
    wr_en = we && wr_rdy && wa_hit;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    for (int r = 0; r < NREGS; r++) rf_d[r] = rf_q[r];

    case (state_q)
      ST_IDLE: begin
        for (int r = 0; r < NREGS; r++) begin
          if (wr_en && (wa == AW'(r))) rf_d[r] = wr_merged;
        end
        if (clr_req) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      ST_CLEAR: begin
        for (int r = 0; r < NREGS; r++) begin
          if (ptr_q == AW'(r)) rf_d[r] = image_of(r);
        end
        if (ptr_q == LAST_IDX) state_d = ST_DONE;
        else                   ptr_d   = ptr_q + 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Out-of-range read addresses match no register and return zero.
  always_comb begin
    rd = '0;
    for (int k = 0; k < NRD; k++) begin
      for (int r = 0; r < NREGS; r++) begin
        if (ra[k*AW +: AW] == AW'(r)) rd[k*DATA_W +: DATA_W] = rf_q[r];
      end
`ifdef VRF_WRITE_BYPASS_EN
      if (wr_en && (ra[k*AW +: AW] == wa)) rd[k*DATA_W +: DATA_W] = wr_merged;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      // NOTE: the register array is reset on purpose: the reset image is
      // architecturally visible, so this storage must be flops, not a RAM macro.
      for (int r = 0; r < NREGS; r++) rf_q[r] <= image_of(r);
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      for (int r = 0; r < NREGS; r++) rf_q[r] <= rf_d[r];
    end
  end

endmodule

// File: tb/tb_vector_reg_file.sv
// Directed self-checking bench for vector_reg_file: reset image, masked writes,
// out-of-range addressing, bulk clear, reset mid-clear and the optional write bypass.
module tb_vector_reg_file;

  localparam int LANES  = 16;
  localparam int DATA_W = 128;
  localparam int NRD    = 3;
  localparam int AW     = 4;

  localparam logic [DATA_W-1:0] R0_IMG = {16{8'hFA}};
  localparam logic [DATA_W-1:0] SP_IMG = 128'h2000;
  localparam logic [DATA_W-1:0] DIRTY  = {16{8'hAA}};

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic                  we, clr_req, wr_rdy, clr_busy, clr_done;
  logic [AW-1:0]         wa;
  logic [DATA_W-1:0]     wd;
  logic [LANES-1:0]      wmask;
  logic [NRD*AW-1:0]     ra;
  logic [NRD*DATA_W-1:0] rd;

  logic                  we_s, clr_req_s, wr_rdy_s, clr_busy_s, clr_done_s;
  logic [AW-1:0]         wa_s;
  logic [DATA_W-1:0]     wd_s;
  logic [LANES-1:0]      wmask_s;
  logic [NRD*AW-1:0]     ra_s;
  logic [NRD*DATA_W-1:0] rd_s;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  vector_reg_file dut (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .wmask(wmask), .wr_rdy(wr_rdy),
    .ra(ra), .rd(rd), .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  vector_reg_file #(.NREGS(12)) dut12 (
    .clk(clk), .rst(rst), .we(we_s), .wa(wa_s), .wd(wd_s), .wmask(wmask_s), .wr_rdy(wr_rdy_s),
    .ra(ra_s), .rd(rd_s), .clr_req(clr_req_s), .clr_busy(clr_busy_s), .clr_done(clr_done_s)
  );

  function automatic logic [DATA_W-1:0] img16(input int r);
    if (r == 0)  return R0_IMG;
    if (r == 13) return SP_IMG;
    return '0;
  endfunction

  task automatic write_reg(input logic [AW-1:0] a, input logic [DATA_W-1:0] d,
                           input logic [LANES-1:0] m);
    @(negedge clk);
    we = 1'b1; wa = a; wd = d; wmask = m;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic read0(input logic [AW-1:0] a, output logic [DATA_W-1:0] d);
    ra[AW-1:0] = a;
    #1;
    d = rd[DATA_W-1:0];
  endtask

  task automatic test_reset;
    logic [DATA_W-1:0] got;
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if ({wr_rdy, clr_busy, clr_done} !== 3'b100) begin
      miscompares++;
      $display("FAIL reset_ctrl: got {wr_rdy,busy,done}=%b want 100", {wr_rdy, clr_busy, clr_done});
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ra = {4'd5, 4'd13, 4'd0};
    #1;
    for (int k = 0; k < NRD; k++) begin
      got = rd[k*DATA_W +: DATA_W];
      vectors++;
      if (got !== img16(k == 0 ? 0 : (k == 1 ? 13 : 5))) begin
        miscompares++;
        $display("FAIL reset_port%0d: got %h want %h", k, got, img16(k == 0 ? 0 : (k == 1 ? 13 : 5)));
      end
    end
  endtask

  task automatic test_masked_write;
    logic [DATA_W-1:0] got;
    logic [DATA_W-1:0] exp;
    write_reg(4'd3, 128'h0F0E0D0C0B0A09080706050403020100, 16'h00FF);
    exp = 128'h0000000000000000_0706050403020100;
    read0(4'd3, got);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL mask_low: got %h want %h", got, exp);
    end
    write_reg(4'd3, {16{8'hFF}}, 16'h0000);
    read0(4'd3, got);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL mask_zero_noop: got %h want %h", got, exp);
    end
    write_reg(4'd3, {16{8'hFF}}, 16'hF000);
    exp = 128'hFFFFFFFF00000000_0706050403020100;
    read0(4'd3, got);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL mask_high: got %h want %h", got, exp);
    end
    read0(4'd4, got);
    vectors++;
    if (got !== '0) begin
      miscompares++;
      $display("FAIL mask_neighbour: got %h want 0", got);
    end
  endtask

  task automatic test_out_of_range;
    logic [DATA_W-1:0] got;
    logic [DATA_W-1:0] exp;
    @(negedge clk);
    we_s = 1'b1; wa_s = 4'd14; wd_s = {16{8'h55}}; wmask_s = '1;
    @(negedge clk);
    we_s = 1'b0;
    ra_s = {4'd15, 4'd12, 4'd14};
    #1;
    vectors++;
    if (rd_s !== '0) begin
      miscompares++;
      $display("FAIL oor_read: got %h want 0", rd_s);
    end
    for (int r = 0; r < 12; r++) begin
      ra_s[AW-1:0] = AW'(r);
      #1;
      got = rd_s[DATA_W-1:0];
      exp = (r == 0) ? R0_IMG : '0;
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL oor_reg%0d: got %h want %h", r, got, exp);
      end
    end
    @(negedge clk);
    we_s = 1'b1; wa_s = 4'd11;
    @(negedge clk);
    we_s = 1'b0;
    ra_s[AW-1:0] = 4'd11;
    #1;
    vectors++;
    if (rd_s[DATA_W-1:0] !== {16{8'h55}}) begin
      miscompares++;
      $display("FAIL oor_last_reg: got %h want %h", rd_s[DATA_W-1:0], {16{8'h55}});
    end
  endtask

  task automatic test_bypass;
    logic [DATA_W-1:0] exp;
    logic [DATA_W-1:0] merged;
    write_reg(4'd2, {16{8'h33}}, '1);
    @(negedge clk);
    we = 1'b1; wa = 4'd2; wd = {16{8'h5A}}; wmask = '1;
    ra = {4'd3, 4'd2, 4'd2};
    #1;
`ifdef VRF_WRITE_BYPASS_EN
    exp = {16{8'h5A}};
`else
    exp = {16{8'h33}};
`endif
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (rd[k*DATA_W +: DATA_W] !== exp) begin
        miscompares++;
        $display("FAIL bypass_full_port%0d: got %h want %h", k, rd[k*DATA_W +: DATA_W], exp);
      end
    end
    vectors++;
    if (rd[2*DATA_W +: DATA_W] !== 128'hFFFFFFFF00000000_0706050403020100) begin
      miscompares++;
      $display("FAIL bypass_other_port: got %h want %h", rd[2*DATA_W +: DATA_W],
               128'hFFFFFFFF00000000_0706050403020100);
    end
    @(negedge clk);
    wd = {16{8'hC3}}; wmask = 16'h0001;
    #1;
    merged = {{15{8'h5A}}, 8'hC3};
`ifdef VRF_WRITE_BYPASS_EN
    exp = merged;
`else
    exp = {16{8'h5A}};
`endif
    vectors++;
    if (rd[DATA_W-1:0] !== exp) begin
      miscompares++;
      $display("FAIL bypass_partial: got %h want %h", rd[DATA_W-1:0], exp);
    end
    @(negedge clk);
    we = 1'b0;
    #1;
    vectors++;
    if (rd[DATA_W-1:0] !== merged) begin
      miscompares++;
      $display("FAIL bypass_after_edge: got %h want %h", rd[DATA_W-1:0], merged);
    end
  endtask

  task automatic test_bulk_clear;
    logic [DATA_W-1:0] got;
    int n;
    int busy_cnt;
    int stray;
    for (int r = 0; r < 16; r++) write_reg(AW'(r), DIRTY, '1);
    read0(4'd13, got);
    vectors++;
    if (got !== DIRTY) begin
      miscompares++;
      $display("FAIL clear_dirty: got %h want %h", got, DIRTY);
    end
    @(negedge clk);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    n = 0;
    busy_cnt = 0;
    while (clr_done !== 1'b1 && n < 40) begin
      if (clr_busy === 1'b1) busy_cnt++;
      if (n == 3) begin
        vectors++;
        if (wr_rdy !== 1'b0) begin
          miscompares++;
          $display("FAIL clear_wr_rdy: got %b want 0", wr_rdy);
        end
        we = 1'b1; wa = 4'd5; wd = {16{8'h11}}; wmask = '1;
      end
      if (n == 4) we = 1'b0;
      if (n == 5) begin
        ra = {4'd13, 4'd4, 4'd5};
        #1;
        vectors++;
        if (rd !== {DIRTY, 128'h0, DIRTY}) begin
          miscompares++;
          $display("FAIL clear_partial_read: got %h want %h", rd, {DIRTY, 128'h0, DIRTY});
        end
      end
      if (n == 8) clr_req = 1'b1;
      if (n == 9) clr_req = 1'b0;
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n != 16 || busy_cnt != 16) begin
      miscompares++;
      $display("FAIL clear_latency: got done_at=%0d busy=%0d want 16 16", n, busy_cnt);
    end
    vectors++;
    if ({clr_busy, wr_rdy} !== 2'b00) begin
      miscompares++;
      $display("FAIL clear_done_state: got {busy,wr_rdy}=%b want 00", {clr_busy, wr_rdy});
    end
    @(negedge clk);
    vectors++;
    if ({clr_done, wr_rdy} !== 2'b01) begin
      miscompares++;
      $display("FAIL clear_done_pulse: got {done,wr_rdy}=%b want 01", {clr_done, wr_rdy});
    end
    we = 1'b1; wa = 4'd4; wd = {16{8'h77}}; wmask = '1;
    @(negedge clk);
    we = 1'b0;
    read0(4'd4, got);
    vectors++;
    if (got !== {16{8'h77}}) begin
      miscompares++;
      $display("FAIL clear_first_write: got %h want %h", got, {16{8'h77}});
    end
    for (int r = 0; r < 16; r++) begin
      if (r != 4) begin
        read0(AW'(r), got);
        vectors++;
        if (got !== img16(r)) begin
          miscompares++;
          $display("FAIL clear_image_reg%0d: got %h want %h", r, got, img16(r));
        end
      end
    end
    stray = 0;
    repeat (20) begin
      @(negedge clk);
      if (clr_busy !== 1'b0 || clr_done !== 1'b0) stray++;
    end
    vectors++;
    if (stray != 0) begin
      miscompares++;
      $display("FAIL clear_not_queued: got %0d busy/done cycles want 0", stray);
    end
  endtask

  task automatic test_reset_mid_clear;
    int stray;
    write_reg(4'd3, DIRTY, '1);
    write_reg(4'd10, DIRTY, '1);
    @(negedge clk);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (7) @(negedge clk);
    vectors++;
    if (clr_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midclr_busy: got %b want 1", clr_busy);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if ({wr_rdy, clr_busy, clr_done} !== 3'b100) begin
      miscompares++;
      $display("FAIL midclr_ctrl: got {wr_rdy,busy,done}=%b want 100", {wr_rdy, clr_busy, clr_done});
    end
    ra = {4'd13, 4'd10, 4'd3};
    #1;
    vectors++;
    if (rd !== {SP_IMG, 128'h0, 128'h0}) begin
      miscompares++;
      $display("FAIL midclr_image: got %h want %h", rd, {SP_IMG, 128'h0, 128'h0});
    end
    ra[AW-1:0] = 4'd0;
    #1;
    vectors++;
    if (rd[DATA_W-1:0] !== R0_IMG) begin
      miscompares++;
      $display("FAIL midclr_reg0: got %h want %h", rd[DATA_W-1:0], R0_IMG);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    stray = 0;
    repeat (20) begin
      @(negedge clk);
      if (clr_busy !== 1'b0 || clr_done !== 1'b0 || wr_rdy !== 1'b1) stray++;
    end
    vectors++;
    if (stray != 0) begin
      miscompares++;
      $display("FAIL midclr_idle: got %0d non-idle cycles want 0", stray);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    we = 1'b0; wa = '0; wd = '0; wmask = '0; ra = '0; clr_req = 1'b0;
    we_s = 1'b0; wa_s = '0; wd_s = '0; wmask_s = '0; ra_s = '0; clr_req_s = 1'b0;
    test_reset();
    test_masked_write();
    test_out_of_range();
    test_bypass();
    test_bulk_clear();
    test_reset_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vector_reg_file.md
Name: vector_reg_file

Overview:
- Parametrised SIMD vector register file. Successor to the fixed 15x128-bit file used by the vector datapath.
- Generalised in lane count, lane width, register count and read-port count.
- Adds per-lane write masking, optional same-cycle write bypass, and a sequential bulk-clear engine that restores the reset image with a ready/done handshake.
- Sits between the decode stage (read ports) and the writeback stage (write port).

Parameters:
- LANES, 16, number of SIMD lanes.
- LANE_W, 8, bits per lane. DATA_W = LANES*LANE_W (default 128).
- NREGS, 16, number of architectural vector registers. AW = $clog2(NREGS).
- NRD, 3, number of independent read ports.
- R0_LANE_INIT, 8'hFA, lane value replicated into register 0 in the reset image.
- SP_IDX, 13, index of the base-pointer register in the reset image.
- SP_INIT, 128'h2000, reset-image value of register SP_IDX, zero-extended or truncated to DATA_W.

Ports:
- clk, in, 1, sole clock. All state updates on the posedge.
- rst, in, 1, asynchronous, active-low reset. Asserted when 0.
- we, in, 1, write request.
- wa, in, AW, write address.
- wd, in, DATA_W, write data. Lane i occupies bits [i*LANE_W +: LANE_W].
- wmask, in, LANES, per-lane write enable. 1 = lane written.
- wr_rdy, out, 1, write port accepting. A write occurs only when we && wr_rdy.
- ra, in, NRD*AW, flattened read addresses. Port k occupies [k*AW +: AW].
- rd, out, NRD*DATA_W, flattened read data. Port k occupies [k*DATA_W +: DATA_W]. Combinational.
- clr_req, in, 1, bulk-clear request. Level sampled.
- clr_busy, out, 1, clear engine active.
- clr_done, out, 1, one-cycle pulse when the clear completes.

Behaviour:
- Reset image: reg0 = {LANES{R0_LANE_INIT}}, reg SP_IDX = SP_INIT, all others 0.
- rst=0 asynchronously does all of the following:
  - loads the full reset image;
  - sets FSM = IDLE and pointer = 0;
  - drives clr_busy=0, clr_done=0, wr_rdy=1.
  - Reset mid-clear aborts the clear. No clr_done is issued.
- Write:
  - On posedge with we && wr_rdy && wa < NREGS, each lane i with wmask[i]=1 takes wd's lane i. Other lanes hold.
  - wmask = 0 is a legal no-op.
  - wa >= NREGS: write dropped silently.
- Read: rd port k = rf[ra_k], combinational. ra_k >= NREGS returns 0. All ports are independent, and any ports may share an address.
- Clear FSM, states IDLE, CLEAR, DONE:
  - IDLE: wr_rdy=1, clr_busy=0. If clr_req=1 at posedge, go to CLEAR with ptr=0.
  - CLEAR: wr_rdy=0, clr_busy=1.
    - Each posedge writes the reset-image value of register ptr into rf[ptr] and increments ptr.
    - After writing ptr = NREGS-1, go to DONE.
    - Occupies exactly NREGS cycles.
  - DONE: clr_done=1, clr_busy=0, wr_rdy=0 for one cycle, then IDLE.
  - Latency: with clr_req sampled at edge E, clr_done is high during the cycle after edge E+NREGS. The first post-clear write is accepted at edge E+NREGS+2.
- Simultaneous and boundary cases:
  - clr_req in CLEAR or DONE is ignored. It is not queued.
  - we && clr_req in IDLE at the same edge: the write is performed, then the clear begins and later overwrites it.
  - we while wr_rdy=0: dropped. The producer must hold the request until wr_rdy=1.
  - Reads during CLEAR return current array contents. Registers below ptr are already restored; registers at or above ptr still hold old data.

Optional Feature:
- Macro: VRF_WRITE_BYPASS_EN.
- Defined: if we && wr_rdy && wa < NREGS && ra_k == wa, rd port k returns the merged value in the same cycle. Lanes with wmask=1 come from wd; other lanes come from rf[wa].
- Undefined: rd returns pre-write contents, and the new value is visible the cycle after the edge.
- Bypass never applies during CLEAR, because wr_rdy=0.

Test Plan:
- Reset values: hold rst=0 then release; read regs 0, 13, 5 -> 0xFAFA...FA, 0x...2000, 0.
- Masked write: write wa=3, wd=0x0F0E...0100, wmask=16'h00FF; then read reg 3 -> lanes 0-7 = 0x00..0x07, lanes 8-15 = 0.
- Out-of-range address: with NREGS=12, write wa=14 -> no register changes; read ra=14 -> 0.
- Bulk clear:
  - Dirty all registers with 0xAA lanes.
  - Pulse clr_req at edge E -> clr_busy high for 16 cycles, clr_done high 1 cycle after edge E+16.
  - Afterwards the reset image is restored.
  - A write attempted during the clear is dropped.
- Reset mid-clear: assert rst=0 at ptr=7 -> clr_busy and clr_done go to 0 immediately, all registers hold the reset image, FSM is IDLE.
- Bypass:
  - Write wa=2 with full mask, with ra port0=2 in the same cycle.
  - Macro defined -> rd0 = wd in that cycle.
  - Macro undefined -> rd0 = old value, then wd the next cycle.
